// File: rtl/matmul_pkg.sv
// Shared defaults and FSM state encoding for the sequential matrix multiplier.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package matmul_pkg;

  localparam int N_DEF  = 8;
  localparam int AW_DEF = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_DRAIN = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  // Index counter width; at least one bit so N=1 still elaborates.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/matmul_seq_if.sv
// Control/address bundle between the matmul sequencer and its memories/MAC.
// Latency: n/a (wires only).
// Backpressure: none; the sequencer free-runs once started.
// abort only exists when MATMUL_SEQ_ABORT_EN is defined.
interface matmul_seq_if #(parameter int AW = 8);

  logic          start;
  logic          rd_en;
  logic [AW-1:0] a_addr;
  logic [AW-1:0] b_addr;
  logic          mac_en;
  logic          mac_clr;
  logic          c_we;
  logic [AW-1:0] c_addr;
  logic          busy;
  logic          done;

`ifdef MATMUL_SEQ_ABORT_EN
  logic          abort;

  modport master (
    input  start, abort,
    output rd_en, a_addr, b_addr, mac_en, mac_clr, c_we, c_addr, busy, done
  );
  modport slave (
    output start, abort,
    input  rd_en, a_addr, b_addr, mac_en, mac_clr, c_we, c_addr, busy, done
  );
`else
  modport master (
    input  start,
    output rd_en, a_addr, b_addr, mac_en, mac_clr, c_we, c_addr, busy, done
  );
  modport slave (
    output start,
    input  rd_en, a_addr, b_addr, mac_en, mac_clr, c_we, c_addr, busy, done
  );
`endif

endinterface

// File: rtl/matmul_idx_cnt.sv
// Nested i/j/k loop counters for C = A x B with wrap and last-element flags.
// Latency: counters move on the edge after their increment enable.
// Backpressure: none; increments are single-cycle enables from the sequencer.
module matmul_idx_cnt
  import matmul_pkg::*;
#(
  parameter  int N  = N_DEF,
  localparam int IW = idx_w(N)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          clr,
  input  logic          k_inc,
  input  logic          ij_inc,
  output logic [IW-1:0] i,
  output logic [IW-1:0] j,
  output logic [IW-1:0] k,
  output logic          k_last,
  output logic          elem_last
);

  localparam logic [IW-1:0] LAST = IW'(N - 1);

  logic i_last;
  logic j_last;

  assign k_last    = (k == LAST);
  assign j_last    = (j == LAST);
  assign i_last    = (i == LAST);
  assign elem_last = i_last & j_last;

  // k walks the dot product; j advances per written element, i on j wrap.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      i <= '0;
      j <= '0;
      k <= '0;
    end else if (clr) begin
      i <= '0;
      j <= '0;
      k <= '0;
    end else begin
      if (k_inc) k <= k_last ? '0 : k + 1'b1;
      if (ij_inc) begin
        j <= j_last ? '0 : j + 1'b1;
        if (j_last) i <= i_last ? '0 : i + 1'b1;
      end
    end
  end

endmodule

// File: rtl/matmul_seq.sv
// Sequencer for C = A x B: per element N reads, one MAC drain, one C write.
// Latency: first rd_en 1 cycle after start, done N*N*(N+2)+1 cycles after it.
// Backpressure: none; start is only sampled in IDLE. Option: MATMUL_SEQ_ABORT_EN.
module matmul_seq
  import matmul_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int AW = AW_DEF
) (
  input logic         clk,
  input logic         reset_n,
  matmul_seq_if.master bus
);

  localparam int IW = idx_w(N);

  localparam logic [2:0] IDLE  = ST_IDLE;
  localparam logic [2:0] RUN   = ST_RUN;
  localparam logic [2:0] DRAIN = ST_DRAIN;
  localparam logic [2:0] WRITE = ST_WRITE;
  localparam logic [2:0] DONE  = ST_DONE;

  localparam logic [AW-1:0] N_A = AW'(N);

  // Every C address must be representable without wrap.
  if ((N * N - 1) >= (1 << AW)) begin : g_aw_chk
    $error("matmul_seq: AW too narrow for N*N-1");
  end

  logic [2:0]    state;
  logic [2:0]    state_nxt;
  logic [IW-1:0] i;
  logic [IW-1:0] j;
  logic [IW-1:0] k;
  logic          k_last;
  logic          elem_last;
  logic          in_run;
  logic          in_write;
  logic          busy_w;
  logic          abort_hit;
  logic          mac_en_q;
  logic          mac_clr_q;

  assign in_run   = (state == RUN);
  assign in_write = (state == WRITE);
  assign busy_w   = in_run | (state == DRAIN) | in_write;

`ifdef MATMUL_SEQ_ABORT_EN
  assign abort_hit = bus.abort & busy_w;
`else
  assign abort_hit = 1'b0;
`endif

  // Next-state: fixed RUN(N)/DRAIN/WRITE pattern per element; abort overrides.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = RUN;
      RUN:     if (k_last) state_nxt = DRAIN;
      DRAIN:   state_nxt = WRITE;
      WRITE:   state_nxt = elem_last ? DONE : RUN;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (abort_hit) state_nxt = IDLE;
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  matmul_idx_cnt #(.N(N)) u_idx (
    .clk       (clk),
    .reset_n   (reset_n),
    .clr       (abort_hit),
    .k_inc     (in_run),
    .ij_inc    (in_write),
    .i         (i),
    .j         (j),
    .k         (k),
    .k_last    (k_last),
    .elem_last (elem_last)
  );

  // MAC strobes trail the read by one cycle to match synchronous memory data.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mac_en_q  <= 1'b0;
      mac_clr_q <= 1'b0;
    end else begin
      mac_en_q  <= in_run & ~abort_hit;
      mac_clr_q <= in_run & (k == '0) & ~abort_hit;
    end
  end

  assign bus.rd_en   = in_run;
  assign bus.a_addr  = in_run ? (AW'(i) * N_A + AW'(k)) : '0;
  assign bus.b_addr  = in_run ? (AW'(k) * N_A + AW'(j)) : '0;
  assign bus.mac_en  = mac_en_q;
  assign bus.mac_clr = mac_clr_q;
  assign bus.c_we    = in_write;
  assign bus.c_addr  = in_write ? (AW'(i) * N_A + AW'(j)) : '0;
  assign bus.busy    = busy_w;
  assign bus.done    = (state == DONE);

endmodule

// File: tb/tb_matmul_seq.sv
// Scoreboarded bench for matmul_seq: random A/B, memory + MAC models, ref product.
// Latency: expectations are placed at absolute cycles derived from the start edge.
// Backpressure: none; the monitor samples every falling edge.
module tb_matmul_seq;

  localparam int N  = 8;
  localparam int AW = 8;
  localparam int OP_CYC = N * N * (N + 2);

  typedef struct {int cyc; int a; int b;}      rd_t;
  typedef struct {int cyc; int clr;}           mac_t;
  typedef struct {int cyc; int addr; int val;} wr_t;

  logic clk;
  logic reset_n;
  int   cyc;
  int   t0;
  int   npass;
  int   ntot;

  int A [N*N];
  int B [N*N];
  int a_q;
  int b_q;
  int acc;

  rd_t  rdq[$];
  mac_t macq[$];
  wr_t  wrq[$];
  int   doneq[$];

  matmul_seq_if #(.AW(AW)) bus ();

  matmul_seq #(.N(N), .AW(AW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Operand memories with one-cycle read latency, plus the MAC they feed.
  always @(posedge clk) begin
    if (bus.rd_en) begin
      a_q <= A[int'(bus.a_addr) % (N*N)];
      b_q <= B[int'(bus.b_addr) % (N*N)];
    end
    if (bus.mac_en) acc <= bus.mac_clr ? a_q * b_q : acc + a_q * b_q;
  end

  task automatic chk(input bit ok, input string nm, input longint act, input longint exp);
    ntot++;
    if (ok) npass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
  endtask

  task automatic refill();
    for (int e = 0; e < N*N; e++) begin
      A[e] = int'($urandom_range(0, 255));
      B[e] = int'($urandom_range(0, 255));
    end
  endtask

  // Reference: plain triple loop, events placed by the documented cycle schedule.
  task automatic push_op(input int base);
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        int e;
        int t;
        int sum;
        e = i * N + j;
        t = base + e * (N + 2);
        sum = 0;
        for (int k = 0; k < N; k++) begin
          rdq.push_back('{t + 1 + k, i * N + k, k * N + j});
          macq.push_back('{t + 2 + k, (k == 0) ? 1 : 0});
          sum += A[i*N+k] * B[k*N+j];
        end
        wrq.push_back('{t + N + 2, e, sum});
      end
    end
    doneq.push_back(base + OP_CYC + 1);
  endtask

  task automatic flush();
    rdq.delete();
    macq.delete();
    wrq.delete();
    doneq.delete();
  endtask

  // Call at a falling edge: raises start so the next rising edge is cycle 0.
  task automatic do_start(input bit hold);
    bus.start = 1'b1;
    @(posedge clk);
    t0 = cyc;
    push_op(t0);
    if (!hold) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
  endtask

  task automatic wait_cycle(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic chk_all_zero(input string nm);
    chk({bus.rd_en, bus.mac_en, bus.mac_clr, bus.c_we, bus.busy, bus.done} == 6'b0,
        {nm, "_strobes"}, {bus.rd_en, bus.mac_en, bus.mac_clr, bus.c_we, bus.busy, bus.done}, 0);
    chk({bus.a_addr, bus.b_addr, bus.c_addr} == '0, {nm, "_addrs"},
        {bus.a_addr, bus.b_addr, bus.c_addr}, 0);
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents an event.
  always @(negedge clk) begin : mon
    rd_t  r;
    mac_t m;
    wr_t  w;
    int   d;
    if (bus.rd_en) begin
      if (rdq.size() == 0) chk(1'b0, "rd_unexpected", 1, 0);
      else begin
        r = rdq.pop_front();
        chk(cyc == r.cyc, "rd_cycle", cyc, r.cyc);
        chk(int'(bus.a_addr) == r.a, "a_addr", bus.a_addr, r.a);
        chk(int'(bus.b_addr) == r.b, "b_addr", bus.b_addr, r.b);
      end
    end else begin
      chk(bus.a_addr == '0 && bus.b_addr == '0, "ab_addr_idle", {bus.a_addr, bus.b_addr}, 0);
    end
    if (bus.mac_en) begin
      if (macq.size() == 0) chk(1'b0, "mac_unexpected", 1, 0);
      else begin
        m = macq.pop_front();
        chk(cyc == m.cyc, "mac_cycle", cyc, m.cyc);
        chk(int'(bus.mac_clr) == m.clr, "mac_clr", bus.mac_clr, m.clr);
      end
    end else begin
      chk(bus.mac_clr == 1'b0, "mac_clr_alone", bus.mac_clr, 0);
    end
    if (bus.c_we) begin
      if (wrq.size() == 0) chk(1'b0, "c_we_unexpected", 1, 0);
      else begin
        w = wrq.pop_front();
        chk(cyc == w.cyc, "c_we_cycle", cyc, w.cyc);
        chk(int'(bus.c_addr) == w.addr, "c_addr", bus.c_addr, w.addr);
        chk(acc == w.val, "c_value", acc, w.val);
      end
    end else begin
      chk(bus.c_addr == '0, "c_addr_idle", bus.c_addr, 0);
    end
    if (bus.done) begin
      if (doneq.size() == 0) chk(1'b0, "done_unexpected", 1, 0);
      else begin
        d = doneq.pop_front();
        chk(cyc == d, "done_cycle", cyc, d);
      end
      chk(bus.busy == 1'b0, "busy_in_done", bus.busy, 0);
    end
    if (bus.rd_en || bus.mac_en || bus.c_we)
      chk(bus.busy == 1'b1, "busy_when_active", bus.busy, 1);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", npass, ntot);
    $fatal(1, "watchdog");
  end

  initial begin
    int t1;
    int t3;
    int t4;
    cyc = 0;
    npass = 0;
    ntot = 0;
    acc = 0;
    a_q = 0;
    b_q = 0;
    reset_n = 1'b0;
    bus.start = 1'b0;
`ifdef MATMUL_SEQ_ABORT_EN
    bus.abort = 1'b0;
`endif
    refill();
    repeat (3) @(negedge clk);
    chk_all_zero("reset_state");

    // Op 1 with start held high: back-to-back op 2 only after DONE->IDLE.
    reset_n = 1'b1;
    do_start(1'b1);
    t1 = t0;
    wait_cycle(t1 + 1);
    chk(bus.rd_en == 1'b1, "first_rd_en", bus.rd_en, 1);
    chk(bus.a_addr == '0 && bus.b_addr == '0, "first_addr", {bus.a_addr, bus.b_addr}, 0);
    wait_cycle(t1 + 2);
    chk(bus.mac_en && bus.mac_clr, "first_mac", {bus.mac_en, bus.mac_clr}, 3);
    wait_cycle(t1 + N + 2);
    chk(bus.c_we && bus.c_addr == '0, "first_c_we", {bus.c_we, bus.c_addr}, 256);
    wait_cycle(t1 + 21 * (N + 2) + 1);
    chk(bus.a_addr == 8'd16 && bus.b_addr == 8'd5, "e25_first", {bus.a_addr, bus.b_addr}, 16*256+5);
    wait_cycle(t1 + 21 * (N + 2) + N);
    chk(bus.a_addr == 8'd23 && bus.b_addr == 8'd61, "e25_last", {bus.a_addr, bus.b_addr}, 23*256+61);
    wait_cycle(t1 + 22 * (N + 2));
    chk(bus.c_we && bus.c_addr == 8'd21, "e25_write", {bus.c_we, bus.c_addr}, 256+21);
    wait_cycle(t1 + 300);
    chk(bus.busy == 1'b1, "busy_mid_run", bus.busy, 1);
    wait_cycle(t1 + OP_CYC + 1);
    chk(bus.done == 1'b1 && bus.busy == 1'b0, "done_641", {bus.done, bus.busy}, 2);
    refill();
    push_op(t1 + OP_CYC + 2);
    wait_cycle(t1 + OP_CYC + 2);
    chk(bus.busy == 1'b0 && bus.done == 1'b0, "idle_between", {bus.busy, bus.done}, 0);
    wait_cycle(t1 + OP_CYC + 3);
    chk(bus.rd_en == 1'b1, "second_op_rd", bus.rd_en, 1);
    bus.start = 1'b0;
    wait_cycle(t1 + 2 * OP_CYC + 3);

    // Op 3 interrupted by reset at cycle 300, then a clean restart.
    @(negedge clk);
    refill();
    do_start(1'b0);
    t3 = t0;
    wait_cycle(t3 + 300);
    #2 reset_n = 1'b0;
    #1 chk_all_zero("reset_mid_op");
    flush();
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    refill();
    do_start(1'b0);
    t4 = t0;
    wait_cycle(t4 + OP_CYC + 1);
    chk(bus.done == 1'b1, "restart_done", bus.done, 1);

`ifdef MATMUL_SEQ_ABORT_EN
    // Abort mid-run: idle on the next cycle, no write or done afterwards.
    @(negedge clk);
    @(negedge clk);
    refill();
    do_start(1'b0);
    t3 = t0;
    wait_cycle(t3 + 55);
    bus.abort = 1'b1;
    @(posedge clk);
    flush();
    @(negedge clk);
    bus.abort = 1'b0;
    chk_all_zero("abort_idle");
    repeat (OP_CYC + 10) @(negedge clk);
    chk(bus.busy == 1'b0, "abort_stays_idle", bus.busy, 0);
`endif

    repeat (5) @(negedge clk);
    chk(rdq.size() == 0, "rdq_drained", rdq.size(), 0);
    chk(macq.size() == 0, "macq_drained", macq.size(), 0);
    chk(wrq.size() == 0, "wrq_drained", wrq.size(), 0);
    chk(doneq.size() == 0, "doneq_drained", doneq.size(), 0);
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule

// File: doc/matmul_seq.md
MATMUL_SEQ -- requirements
Module: matmul_seq

Interface
REQ-001 SHALL have parameter N, default 8, meaning matrix dimension (square N x N operands).
REQ-002 SHALL have parameter AW, default 8, meaning address width of every address port.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  request one full C = A x B operation; sampled only in IDLE.
REQ-006 SHALL have port rd_en  output  1  read strobe for the A and B operand memories.
REQ-007 SHALL have port a_addr  output  AW  A read address, row-major: i*N+k.
REQ-008 SHALL have port b_addr  output  AW  B read address, column walk at stride N: k*N+j.
REQ-009 SHALL have port mac_en  output  1  MAC consumes the operand pair read one cycle earlier.
REQ-010 SHALL have port mac_clr  output  1  with mac_en, MAC loads the product instead of accumulating.
REQ-011 SHALL have port c_we  output  1  write strobe for the C result memory.
REQ-012 SHALL have port c_addr  output  AW  C write address i*N+j.
REQ-013 SHALL have port busy  output  1  high in RUN, DRAIN, WRITE.
REQ-014 SHALL have port done  output  1  one-cycle pulse at completion.

Function
REQ-015 SHALL implement states IDLE, RUN, DRAIN, WRITE, DONE.
REQ-016 IDLE->RUN when start=1; start in any other state SHALL be ignored.
REQ-017 RUN SHALL last N cycles per element, k=0..N-1, rd_en=1 each cycle with a_addr/b_addr for current (i,j,k); then ->DRAIN.
REQ-018 mac_en SHALL equal rd_en delayed one cycle; mac_clr SHALL equal (rd_en and k==0) delayed one cycle.
REQ-019 DRAIN SHALL last one cycle (final mac_en of the element), rd_en=0; then ->WRITE.
REQ-020 WRITE SHALL last one cycle with c_we=1, c_addr=i*N+j; then j increments; at j=N-1 j wraps to 0 and i increments.
REQ-021 After WRITE of (N-1,N-1) SHALL go to DONE, otherwise to RUN with k=0.
REQ-022 DONE SHALL last one cycle, done=1, busy=0; then ->IDLE; start in DONE ignored.
REQ-023 Latency: start sampled at edge 0 -> first rd_en cycle 1, first mac_en/mac_clr cycle 2, first c_we cycle N+2, last c_we cycle N*N*(N+2), done cycle N*N*(N+2)+1 (641 for N=8).
REQ-024 Addresses SHALL be computed in AW bits; N*N-1 SHALL fit AW (elaboration-time check); no wrap at default.
REQ-025 Outside their active cycles a_addr, b_addr, c_addr SHALL hold 0.

Reset
REQ-026 reset_n=0 SHALL immediately force IDLE, i=j=k=0, all outputs 0, including mid-operation; no done after reset.
REQ-027 First start accepted at the first edge after reset_n deasserts.

Configuration
REQ-028 With MATMUL_SEQ_ABORT_EN defined SHALL add input abort (1 bit): abort=1 in RUN/DRAIN/WRITE returns to IDLE next edge, indices cleared, outputs 0, done not pulsed; abort in IDLE/DONE ignored.
REQ-029 Without MATMUL_SEQ_ABORT_EN the abort port and logic SHALL be absent; behaviour otherwise identical.

Structure
REQ-030 Package matmul_pkg SHALL hold default N, AW and the state enum typedef.
REQ-031 Sub-module matmul_idx_cnt SHALL hold the i/j/k nested counters with wrap and last-element flags.

Verification
REQ-032 Reset then start pulse -> cycle 1 rd_en, a=0,b=0; cycle 2 mac_en=mac_clr=1; cycle 10 c_we, c_addr=0.
REQ-033 Full run with A,B memory models and MAC -> C matches reference product; c_addr sequence 0..63; done at cycle 641.
REQ-034 Element (i=2,j=5): a_addr 16..23, b_addr 5,13,...,61, c_addr 21.
REQ-035 start held high throughout -> busy never drops mid-run, second operation begins only after DONE->IDLE.
REQ-036 reset_n low at cycle 300 -> all outputs 0 immediately, no done; restart completes normally.
REQ-037 With MATMUL_SEQ_ABORT_EN: abort at cycle 55 -> IDLE at cycle 56, no further c_we, done stays 0.
